// File: rtl/eaf_bloom_filter_param.sv
// eaf_bloom_filter_param: evicted-address Bloom filter with serial hash probes and auto-clear
module eaf_bloom_filter_param #(
  parameter int ADDR_W      = 32,
  parameter int NUM_ENTRIES = 16,
  parameter int BF_BITS     = 64,
  parameter int NUM_HASH    = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [ADDR_W-1:0]                  mem_addr,
  input  logic                               insert_req_i,
  input  logic                               test_req_i,
  output logic                               busy_o,
  output logic                               resp_o,
  output logic                               addr_exists,
  output logic                               priority_level,
  output logic                               clear_o,
  output logic [$clog2(NUM_ENTRIES+1)-1:0]   entry_count_o
);
  localparam int IDX_W = $clog2(BF_BITS);
  localparam int CNT_W = $clog2(NUM_ENTRIES + 1);
  localparam int PI_W  = (NUM_HASH > 1) ? $clog2(NUM_HASH) : 1;
  typedef enum logic [1:0] {IDLE, PROBE, RESP, CLEAR} state_t;
  state_t             state, state_nx;
  logic [BF_BITS-1:0] bf;
  logic [ADDR_W-1:0]  addr;
  logic               ins, tst, hit_acc;
  logic [PI_W-1:0]    pi;
  logic [CNT_W-1:0]   count, count_inc;
  logic [IDX_W-1:0]   idx;
  logic               bit_hit, last, accept;
  assign idx       = addr[pi*IDX_W +: IDX_W] ^ addr[ADDR_W-1 -: IDX_W] ^ IDX_W'(pi);
  assign bit_hit   = bf[idx];
  assign last      = (pi == PI_W'(NUM_HASH - 1));
  assign accept    = (state == IDLE) && (insert_req_i || test_req_i);
  assign count_inc = count + 1'b1;
  assign entry_count_o = count;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = accept ? PROBE : IDLE;
      // test-only ops stop at the first clear bit; inserts must visit every probe
      PROBE:   state_nx = (last || (!ins && !bit_hit)) ? RESP : PROBE;
      RESP:    state_nx = (ins && count_inc == CNT_W'(NUM_ENTRIES)) ? CLEAR : IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    busy_o         = (state != IDLE);
    resp_o         = (state == RESP);
    addr_exists    = resp_o && tst && hit_acc;
    priority_level = addr_exists;
    clear_o        = (state == CLEAR);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bf      <= '0;
      addr    <= '0;
      ins     <= 1'b0;
      tst     <= 1'b0;
      hit_acc <= 1'b0;
      pi      <= '0;
      count   <= '0;
    end else begin
      if (accept) begin
        addr    <= mem_addr;
        ins     <= insert_req_i;
        tst     <= test_req_i;
        pi      <= '0;
        hit_acc <= 1'b1;
      end
      if (state == PROBE) begin
        hit_acc <= hit_acc && bit_hit;
        pi      <= pi + 1'b1;
        if (ins) bf[idx] <= 1'b1;
      end
      if (state == RESP && ins) count <= count_inc;
      if (state == CLEAR) begin
        bf    <= '0;
        count <= '0;
      end
    end
  end
endmodule

// File: tb/tb_eaf_bloom_filter_param.sv
// tb_eaf_bloom_filter_param: directed checks of insert/test latency, hits, auto-clear and reset
module tb_eaf_bloom_filter_param;
  logic        clk, rst, insert_req_i, test_req_i;
  logic [31:0] mem_addr;
  logic        busy_o, resp_o, addr_exists, priority_level, clear_o;
  logic [4:0]  entry_count_o;
  int          total = 0, passed = 0, fails = 0;
  int          cyc;
  logic        ex, pr;

  eaf_bloom_filter_param dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr),
    .insert_req_i(insert_req_i), .test_req_i(test_req_i),
    .busy_o(busy_o), .resp_o(resp_o), .addr_exists(addr_exists),
    .priority_level(priority_level), .clear_o(clear_o),
    .entry_count_o(entry_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // called just after a rising edge; presents the request for one cycle (cycle 0)
  task automatic start_op(input logic [31:0] a, input logic i, input logic t);
    mem_addr = a;
    insert_req_i = i;
    test_req_i = t;
    @(posedge clk); #1;
    insert_req_i = 1'b0;
    test_req_i = 1'b0;
  endtask

  // counts cycles from the current one (k=1) until resp_o; returns just after the following edge
  task automatic wait_resp(output int c, output logic e, output logic p);
    c = -1;
    e = 1'bx;
    p = 1'bx;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (resp_o) begin
        c = k;
        e = addr_exists;
        p = priority_level;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_op(input logic [31:0] a, input logic i, input logic t,
                       output int c, output logic e, output logic p);
    start_op(a, i, t);
    wait_resp(c, e, p);
  endtask

  initial begin
    rst = 1'b0;
    insert_req_i = 1'b0;
    test_req_i = 1'b0;
    mem_addr = '0;
    #12;
    check("rst_busy", 32'(busy_o), 0);
    check("rst_resp", 32'(resp_o), 0);
    check("rst_clear", 32'(clear_o), 0);
    check("rst_count", 32'(entry_count_o), 0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    do_op(32'h0, 1'b0, 1'b1, cyc, ex, pr);
    check("t0_empty_cyc", 32'(cyc), 2);
    check("t0_empty_exists", 32'(ex), 0);
    check("t0_empty_prio", 32'(pr), 0);

    do_op(32'h0, 1'b1, 1'b0, cyc, ex, pr);
    check("ins0_cyc", 32'(cyc), 5);
    check("ins0_exists", 32'(ex), 0);
    check("ins0_count", 32'(entry_count_o), 1);

    do_op(32'h0, 1'b0, 1'b1, cyc, ex, pr);
    check("t0_hit_cyc", 32'(cyc), 5);
    check("t0_hit_exists", 32'(ex), 1);
    check("t0_hit_prio", 32'(pr), 1);

    do_op(32'h40, 1'b0, 1'b1, cyc, ex, pr);
    check("t40_fp_cyc", 32'(cyc), 5);
    check("t40_fp_exists", 32'(ex), 1);

    do_op(32'h4, 1'b0, 1'b1, cyc, ex, pr);
    check("t4_miss_cyc", 32'(cyc), 2);
    check("t4_miss_exists", 32'(ex), 0);
    check("t4_count", 32'(entry_count_o), 1);

    start_op(32'h123, 1'b1, 1'b0);
    @(posedge clk); #1;
    check("mid_busy_pre", 32'(busy_o), 1);
    rst = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy_o), 0);
    check("mid_rst_resp", 32'(resp_o), 0);
    check("mid_rst_count", 32'(entry_count_o), 0);
    @(negedge clk);
    check("mid_rst_resp_hold", 32'(resp_o), 0);
    rst = 1'b1;
    @(posedge clk); #1;

    do_op(32'h8, 1'b1, 1'b1, cyc, ex, pr);
    check("ti8_cyc", 32'(cyc), 5);
    check("ti8_exists", 32'(ex), 0);
    check("ti8_prio", 32'(pr), 0);
    check("ti8_count", 32'(entry_count_o), 1);

    do_op(32'h8, 1'b0, 1'b1, cyc, ex, pr);
    check("t8_cyc", 32'(cyc), 5);
    check("t8_exists", 32'(ex), 1);

    start_op(32'h100, 1'b1, 1'b0);
    check("drop_busy", 32'(busy_o), 1);
    start_op(32'h200, 1'b1, 1'b1);
    wait_resp(cyc, ex, pr);
    check("drop_resp_cyc", 32'(cyc), 4);
    check("drop_exists", 32'(ex), 0);
    check("drop_count", 32'(entry_count_o), 2);
    repeat (3) @(posedge clk);
    #1;
    check("drop_idle", 32'(busy_o), 0);
    check("drop_count_hold", 32'(entry_count_o), 2);

    rst = 1'b0;
    #1;
    check("rst2_count", 32'(entry_count_o), 0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= 16; k++) begin
      do_op(32'h1111 * k, 1'b1, 1'b0, cyc, ex, pr);
      if (k < 16) begin
        check($sformatf("fill%0d_count", k), 32'(entry_count_o), 32'(k));
        check($sformatf("fill%0d_noclr", k), 32'(clear_o), 0);
      end
    end
    check("clr_pulse", 32'(clear_o), 1);
    check("clr_busy", 32'(busy_o), 1);
    check("clr_count_full", 32'(entry_count_o), 16);
    @(posedge clk); #1;
    check("clr_done", 32'(clear_o), 0);
    check("clr_count_zero", 32'(entry_count_o), 0);
    check("clr_idle", 32'(busy_o), 0);
    do_op(32'h0, 1'b0, 1'b1, cyc, ex, pr);
    check("post_clr_cyc", 32'(cyc), 2);
    check("post_clr_exists", 32'(ex), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
